case_mul_pipe_hs: RTL and testbench

- Parametrised, pipelined signed/unsigned multiplier with a valid/ready handshake and a sideband tag.
- Successor to the single-cycle combinational operator cores in the generated kernels; used where the scheduler needs multi-cycle multiplies with backpressure.
- The product is narrowed to dout_WIDTH by wrap truncation, or by saturation when the optional feature is compiled in.

---
 rtl/case_mul_pipe_hs.sv | 161 ++++++++++++++++
 tb/tb_case_mul_pipe_hs.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/case_mul_pipe_hs.sv
// Pipelined signed/unsigned multiplier with valid/ready handshake and sideband tag.
// Define CASE_MUL_SAT_EN to saturate the narrowed result (and drive ovf) instead of wrapping.
module case_mul_pipe_hs #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 13,
  parameter int din1_WIDTH = 7,
  parameter int dout_WIDTH = 13,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  mode,
  input  logic [TAG_WIDTH-1:0]  tag_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic [TAG_WIDTH-1:0]  tag_out,
  output logic                  ovf
);

  localparam int PW = din0_WIDTH + din1_WIDTH;

  generate
    if (NUM_STAGE < 1 || NUM_STAGE > 8) begin : g_bad_stage
      $error("case_mul_pipe_hs: NUM_STAGE must be in 1..8");
    end
    if (dout_WIDTH > PW) begin : g_bad_width
      $error("case_mul_pipe_hs: dout_WIDTH exceeds the full product width");
    end
  endgenerate

  logic advance;
  logic last_vld;

  // A stalled last slice freezes the whole pipe, bubbles included.
  assign advance   = ~last_vld | out_ready;
  assign in_ready  = advance;
  assign out_valid = last_vld;

  logic [PW-1:0] a_ext;
  logic [PW-1:0] b_ext;
  logic [PW-1:0] prod;

  assign a_ext = {{din1_WIDTH{mode & din0[din0_WIDTH-1]}}, din0};
  assign b_ext = {{din0_WIDTH{mode & din1[din1_WIDTH-1]}}, din1};
  assign prod  = a_ext * b_ext;

  logic                 nar_vld;
  logic [PW-1:0]        nar_prod;
  logic [TAG_WIDTH-1:0] nar_tag;
`ifdef CASE_MUL_SAT_EN
  logic                 nar_mode;
`endif

  generate
    if (NUM_STAGE == 1) begin : g_direct
      assign nar_vld  = in_valid;
      assign nar_prod = prod;
      assign nar_tag  = tag_in;
`ifdef CASE_MUL_SAT_EN
      assign nar_mode = mode;
`endif
    end else begin : g_delay
      localparam int D = NUM_STAGE - 1;

      logic [D:1]           vld_q;
      logic [PW-1:0]        prod_q [1:D];
      logic [TAG_WIDTH-1:0] tag_q  [1:D];
`ifdef CASE_MUL_SAT_EN
      logic [D:1]           mode_q;
`endif

      // Full-width product slices; the last of these feeds the narrowing logic.
      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          vld_q <= '0;
          for (int i = 1; i <= D; i++) begin
            prod_q[i] <= '0;
            tag_q[i]  <= '0;
          end
`ifdef CASE_MUL_SAT_EN
          mode_q <= '0;
`endif
        end else if (advance) begin
          vld_q[1]  <= in_valid;
          prod_q[1] <= prod;
          tag_q[1]  <= tag_in;
`ifdef CASE_MUL_SAT_EN
          mode_q[1] <= mode;
`endif
          for (int i = 2; i <= D; i++) begin
            vld_q[i]  <= vld_q[i-1];
            prod_q[i] <= prod_q[i-1];
            tag_q[i]  <= tag_q[i-1];
`ifdef CASE_MUL_SAT_EN
            mode_q[i] <= mode_q[i-1];
`endif
          end
        end
      end

      assign nar_vld  = vld_q[D];
      assign nar_prod = prod_q[D];
      assign nar_tag  = tag_q[D];
`ifdef CASE_MUL_SAT_EN
      assign nar_mode = mode_q[D];
`endif
    end
  endgenerate

  logic [dout_WIDTH-1:0] nar_dout;

`ifdef CASE_MUL_SAT_EN
  logic                 nar_ovf;
  logic signed [PW-1:0] hi_bits;

  // Signed results fit when every bit from the dout sign bit upward agrees.
  always_comb begin
    nar_dout = nar_prod[dout_WIDTH-1:0];
    nar_ovf  = 1'b0;
    hi_bits  = $signed(nar_prod) >>> (dout_WIDTH - 1);
    if (nar_mode) begin
      if (hi_bits != '0 && hi_bits != '1) begin
        nar_ovf  = 1'b1;
        nar_dout = nar_prod[PW-1] ? {1'b1, {(dout_WIDTH-1){1'b0}}}
                                  : {1'b0, {(dout_WIDTH-1){1'b1}}};
      end
    end else if ((nar_prod >> dout_WIDTH) != '0) begin
      nar_ovf  = 1'b1;
      nar_dout = '1;
    end
  end
`else
  assign nar_dout = nar_prod[dout_WIDTH-1:0];
  assign ovf      = 1'b0;
`endif

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      last_vld <= 1'b0;
      dout     <= '0;
      tag_out  <= '0;
`ifdef CASE_MUL_SAT_EN
      ovf      <= 1'b0;
`endif
    end else if (advance) begin
      last_vld <= nar_vld;
      dout     <= nar_dout;
      tag_out  <= nar_tag;
`ifdef CASE_MUL_SAT_EN
      ovf      <= nar_ovf;
`endif
    end
  end

endmodule

// File: tb/tb_case_mul_pipe_hs.sv
// Self-checking bench for case_mul_pipe_hs (default parameters); follows CASE_MUL_SAT_EN
// to pick wrap or saturation expectations.
module tb_case_mul_pipe_hs;

  logic        ap_clk   = 1'b0;
  logic        ap_rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [12:0] din0     = '0;
  logic [6:0]  din1     = '0;
  logic        mode     = 1'b0;
  logic [3:0]  tag_in   = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [12:0] dout;
  logic [3:0]  tag_out;
  logic        ovf;

  int compared   = 0;
  int mismatched = 0;

  always #5 ap_clk = ~ap_clk;

  case_mul_pipe_hs #(
    .ID(1), .NUM_STAGE(3), .din0_WIDTH(13), .din1_WIDTH(7), .dout_WIDTH(13), .TAG_WIDTH(4)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1), .mode(mode), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .tag_out(tag_out), .ovf(ovf)
  );

  typedef struct {
    logic        m;
    logic [12:0] a;
    logic [6:0]  b;
    logic [3:0]  t;
    logic [12:0] wrap_d;
    logic [12:0] sat_d;
    logic        sat_ovf;
  } vec_t;

  vec_t vecs [9];

  // Every comparison goes through here so the counts stay honest.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    compared++;
    if (actual !== required) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, required);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic m, input logic [12:0] a,
                               input logic [6:0] b, input logic [3:0] t);
    in_valid = v;
    mode     = m;
    din0     = a;
    din1     = b;
    tag_in   = t;
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Integer reference multiply; returns {tag, ovf, dout}.
  function automatic logic [17:0] refMul(input logic m, input logic [12:0] a,
                                         input logic [6:0] b, input logic [3:0] t);
    longint pa, pb, p;
    logic [12:0] d;
    logic o;
    pa = longint'(a);
    if (m && a[12]) pa = pa - 8192;
    pb = longint'(b);
    if (m && b[6]) pb = pb - 128;
    p = pa * pb;
    d = p[12:0];
    o = 1'b0;
`ifdef CASE_MUL_SAT_EN
    if (m) begin
      if (p > 4095) begin d = 13'h0FFF; o = 1'b1; end
      else if (p < -4096) begin d = 13'h1000; o = 1'b1; end
    end else if (p > 8191) begin
      d = 13'h1FFF; o = 1'b1;
    end
`endif
    return {t, o, d};
  endfunction

  initial begin
    logic [12:0] exp_d;
    logic        exp_o;
    logic [17:0] sbq [$];
    logic [17:0] exp_r;
    int          sent;
    int          exp_t;
    logic        exp_rdy;
    logic        exp_vld;

    //            m     a         b      t      wrap      sat       sat_ovf
    vecs[0] = '{1'b1, 13'd100,  7'h7D, 4'd5,  13'h1ED4, 13'h1ED4, 1'b0};
    vecs[1] = '{1'b1, 13'h1000, 7'h40, 4'd6,  13'h0000, 13'h0FFF, 1'b1};
    vecs[2] = '{1'b0, 13'h1FFF, 7'h7F, 4'd7,  13'h1F81, 13'h1FFF, 1'b1};
    vecs[3] = '{1'b1, 13'h1FFF, 7'h7F, 4'd8,  13'h0001, 13'h0001, 1'b0};
    vecs[4] = '{1'b0, 13'h0010, 7'h03, 4'd9,  13'h0030, 13'h0030, 1'b0};
    vecs[5] = '{1'b1, 13'h0FFF, 7'h3F, 4'd10, 13'h0FC1, 13'h0FFF, 1'b1};
    vecs[6] = '{1'b1, 13'h1000, 7'h02, 4'd11, 13'h0000, 13'h1000, 1'b1};
    vecs[7] = '{1'b0, 13'h1000, 7'h02, 4'd12, 13'h0000, 13'h1FFF, 1'b1};
    vecs[8] = '{1'b1, 13'h1000, 7'h01, 4'd13, 13'h1000, 13'h1000, 1'b0};

    #2 ap_rst_n = 1'b0;
    #2;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_dout",      32'(dout),      32'd0);
    checkOutput("reset_tag_out",   32'(tag_out),   32'd0);
    checkOutput("reset_ovf",       32'(ovf),       32'd0);
    checkOutput("reset_in_ready",  32'(in_ready),  32'd1);
    repeat (2) tick();
    ap_rst_n = 1'b1;

    // Single pairs through an idle pipe: latency, arithmetic and narrowing.
    for (int i = 0; i < 9; i++) begin
`ifdef CASE_MUL_SAT_EN
      exp_d = vecs[i].sat_d;
      exp_o = vecs[i].sat_ovf;
`else
      exp_d = vecs[i].wrap_d;
      exp_o = 1'b0;
`endif
      applyStimulus(1'b1, vecs[i].m, vecs[i].a, vecs[i].b, vecs[i].t);
      #1;
      checkOutput("tbl_in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      checkOutput("tbl_valid_c1", 32'(out_valid), 32'd0);
      tick();
      checkOutput("tbl_valid_c2", 32'(out_valid), 32'd0);
      tick();
      checkOutput("tbl_valid_c3", 32'(out_valid), 32'd1);
      checkOutput("tbl_dout",     32'(dout),      32'(exp_d));
      checkOutput("tbl_tag",      32'(tag_out),   32'(vecs[i].t));
      checkOutput("tbl_ovf",      32'(ovf),       32'(exp_o));
      tick();
      checkOutput("tbl_valid_c4", 32'(out_valid), 32'd0);
    end

    // Backpressure: six pairs, out_ready low in cycles 3..7.
    sent = 0;
    for (int k = 0; k < 16; k++) begin
      out_ready = !(k >= 3 && k <= 7);
      exp_rdy   = !(k >= 3 && k <= 7);
      exp_vld   = (k >= 3 && k <= 13);
      if (sent < 6) applyStimulus(1'b1, 1'b0, 13'(10 + sent), 7'd3, 4'(sent));
      else          applyStimulus(1'b0, 1'b0, 13'd0, 7'd0, 4'd0);
      #1;
      checkOutput("bp_in_ready",  32'(in_ready),  32'(exp_rdy));
      checkOutput("bp_out_valid", 32'(out_valid), 32'(exp_vld));
      if (exp_vld) begin
        exp_t = (k <= 7) ? 0 : k - 8;
        checkOutput("bp_tag",  32'(tag_out), 32'(exp_t));
        checkOutput("bp_dout", 32'(dout),    32'(3 * (10 + exp_t)));
      end
      if (sent < 6 && exp_rdy) sent++;
      tick();
    end
    out_ready = 1'b1;

    // Streaming: 20 back-to-back random pairs against the reference model.
    for (int k = 0; k < 24; k++) begin
      if (k < 20) begin
        applyStimulus(1'b1, 1'($urandom_range(0, 1)), 13'($urandom), 7'($urandom), 4'(k));
        sbq.push_back(refMul(mode, din0, din1, tag_in));
      end else begin
        applyStimulus(1'b0, 1'b0, 13'd0, 7'd0, 4'd0);
      end
      #1;
      checkOutput("st_in_ready", 32'(in_ready), 32'd1);
      exp_vld = (k >= 3 && k <= 22);
      checkOutput("st_out_valid", 32'(out_valid), 32'(exp_vld));
      if (exp_vld && sbq.size() > 0) begin
        exp_r = sbq.pop_front();
        checkOutput("st_dout", 32'(dout),    32'(exp_r[12:0]));
        checkOutput("st_ovf",  32'(ovf),     32'(exp_r[13]));
        checkOutput("st_tag",  32'(tag_out), 32'(exp_r[17:14]));
      end
      tick();
    end

    // Reset with three pairs in flight, asserted between edges.
    applyStimulus(1'b1, 1'b0, 13'h1FFF, 7'h7F, 4'hA);
    tick();
    applyStimulus(1'b1, 1'b1, 13'h1000, 7'h40, 4'hB);
    tick();
    applyStimulus(1'b1, 1'b0, 13'h0010, 7'h03, 4'hC);
    tick();
    applyStimulus(1'b0, 1'b0, 13'd0, 7'd0, 4'd0);
    #1;
    checkOutput("rst_pre_valid", 32'(out_valid), 32'd1);
    checkOutput("rst_pre_tag",   32'(tag_out),   32'hA);
    #1;
    ap_rst_n = 1'b0;
    applyStimulus(1'b1, 1'b0, 13'd5, 7'd5, 4'hD);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_dout",      32'(dout),      32'd0);
    checkOutput("rst_tag",       32'(tag_out),   32'd0);
    checkOutput("rst_ovf",       32'(ovf),       32'd0);
    checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
    @(posedge ap_clk);
    #3;
    ap_rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 13'd0, 7'd0, 4'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("rst_no_stale", 32'(out_valid), 32'd0);
    end
    applyStimulus(1'b1, 1'b1, 13'd100, 7'h7D, 4'h5);
    tick();
    in_valid = 1'b0;
    checkOutput("post_rst_c1", 32'(out_valid), 32'd0);
    tick();
    checkOutput("post_rst_c2", 32'(out_valid), 32'd0);
    tick();
    checkOutput("post_rst_c3",   32'(out_valid), 32'd1);
    checkOutput("post_rst_dout", 32'(dout),      32'h1ED4);
    checkOutput("post_rst_tag",  32'(tag_out),   32'h5);
    checkOutput("post_rst_ovf",  32'(ovf),       32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
